// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx, uart_tx and uart_rx_fifo.
// Holds the byte width and the byte type.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage for the receive FIFO.
// Synchronous write, combinational read so the head byte falls through.
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: FWFT FIFO with a sticky overrun flag.
// Define UART_RX_FIFO_LEVEL_EN to add the level and almost_full outputs.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    parameter int AFULL_THRESH = 12
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign overrun   = r_overrun;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (in_data),
        .raddr (r_rd_ptr),
        .rdata (out_data)
    );

    // Pointers wrap naturally; count tracks the net push/pop change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overrun; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_LEVEL_EN
    assign level       = r_count;
    assign almost_full = (r_count >= (ADDR_W+1)'(AFULL_THRESH));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo using a byte scoreboard.
// Level/almost_full checks are built when UART_RX_FIFO_LEVEL_EN is defined.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFT   = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    uart_byte_t in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    uart_byte_t out_data;
    logic       out_valid;
    logic       overrun;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [4:0] level;
    logic       almost_full;
`endif

    int total = 0;
    int bad = 0;
    uart_byte_t sb[$];
    int mcnt = 0;
    logic m_ovr = 1'b0;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef UART_RX_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check_eq("out_valid", 32'(out_valid), 32'(mcnt != 0));
        if (mcnt != 0) check_eq("head", 32'(out_data), 32'(sb[0]));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_FIFO_LEVEL_EN
        check_eq("level", 32'(level), 32'(mcnt));
        check_eq("afull", 32'(almost_full), 32'(mcnt >= AFT));
`endif
    endtask

    // Drive one cycle, update the model, then check after the edge.
    task automatic step(input logic iv, input uart_byte_t d,
                        input logic rdy, input logic clr);
        logic pop;
        logic push;
        in_valid    = iv;
        in_data     = d;
        out_ready   = rdy;
        overrun_clr = clr;
        pop  = (mcnt > 0) && rdy;
        push = iv && ((mcnt < DEPTH) || pop);
        if (pop) check_eq("rd", 32'(out_data), 32'(sb.pop_front()));
        if (push) sb.push_back(d);
        if (iv && !push) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        mcnt = mcnt + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        check_state();
    endtask

    task automatic fill(input uart_byte_t base);
        for (int i = 0; i < DEPTH; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();

        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("t1_data", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t1_empty", 32'(out_valid), 32'h0);

        fill(8'h01);
        drain(DEPTH);

        fill(8'h20);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("t3_set", 32'(overrun), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t3_clr", 32'(overrun), 32'h0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check_eq("t3_setclr", 32'(overrun), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        step(1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("t4_ovr", 32'(overrun), 32'h0);
        check_eq("t4_valid", 32'(out_valid), 32'h1);
        drain(DEPTH);
        check_eq("t4_empty", 32'(out_valid), 32'h0);

        for (int i = 0; i < 40; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
        drain(1);

        fill(8'h40);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        drain(11);
        check_eq("t6_pre_ovr", 32'(overrun), 32'h1);
        check_eq("t6_pre_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #2;
        sb.delete();
        mcnt  = 0;
        m_ovr = 1'b0;
        check_eq("t6_rst_valid", 32'(out_valid), 32'h0);
        check_eq("t6_rst_ovr", 32'(overrun), 32'h0);
`ifdef UART_RX_FIFO_LEVEL_EN
        check_eq("t6_rst_level", 32'(level), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
